balanca_price_entry: RTL
========================

// Module: balanca_price_entry
// PURPOSE
//  Keypad front end for the scale. Collects the price per kg as decimal key
//  digits over a valid/ready handshake and echoes them as BCD for display.
//  On ENTER, converts the digits to binary, one digit per cycle.
//  Publishes the result as the centimos operand consumed by the price datapath.
// PARAMETERS
//  OUT_W       9    width of value_out (binary centimos)
//  MAX_VAL     511  largest committable value; must be <= 2**OUT_W-1
//  MAX_DIGITS  3    digit buffer depth; internal accumulator is 4*MAX_DIGITS bits
// PORTS
//  clk          in   1             rising-edge clock
//  rst_n        in   1             asynchronous active-low reset
//  key_valid    in   1             key_code is presented
//  key_ready    out  1             block can accept a key this cycle
//  key_code     in   4             0-9 digit, A clear, B backspace, E enter, others no-op
//  entry_bcd    out  4*MAX_DIGITS  digits typed so far, right-aligned, newest in [3:0]
//  digit_count  out  $clog2(MAX_DIGITS+1)  number of digits in entry_bcd
//  value_out    out  OUT_W         last successfully committed value
//  value_valid  out  1             one-cycle pulse: value_out was just updated
//  range_err    out  1             one-cycle pulse: commit rejected, value > MAX_VAL
//  digit_drop   out  1             one-cycle pulse: digit ignored, buffer full
// BEHAVIOUR
//  Reset (async, any state): FSM=ENTRY; entry_bcd, digit_count, value_out = 0;
//   value_valid, range_err, digit_drop = 0. A conversion in progress is aborted.
//  Handshake: a key is accepted on a rising edge with key_valid&&key_ready.
//   key_ready = 1 only in ENTRY. A key held during CONVERT/DONE stays pending;
//   it is neither lost nor duplicated.
//  FSM ENTRY (per accepted key):
//   digit, count<MAX_DIGITS: entry_bcd<={entry_bcd,digit} (shift left 4), count+1.
//    Leading zeros count as digits.
//   digit, count==MAX_DIGITS: buffer unchanged; digit_drop=1 next cycle.
//   B: count>0 -> entry_bcd>>4, count-1; count==0 -> no effect.
//   A: entry_bcd=0, count=0.
//   E: acc<=0, idx<=0, -> CONVERT. Other codes: accepted, no effect.
//  FSM CONVERT: max(count,1) cycles, one digit per cycle, oldest digit first.
//   acc<=acc*10+digit[idx] (acc*10 = (acc<<3)+(acc<<1)). An empty buffer
//   converts as the single digit 0. After the last digit -> DONE.
//  FSM DONE: one cycle.
//   acc<=MAX_VAL: value_out<=acc[OUT_W-1:0], value_valid=1.
//   acc>MAX_VAL: value_out unchanged, range_err=1.
//   Either case: entry_bcd=0, count=0, -> ENTRY.
//  Latency: E accepted at edge T with N digits -> value_valid/range_err high
//   during cycle T+max(N,1)+1, then low. key_ready returns the same cycle.
//  value_valid and range_err are never high together. Pulses are registered.
//  entry_bcd and digit_count are frozen during CONVERT and DONE.
//  value_out is held between commits; the downstream datapath samples it freely.
// TESTING
//  keys 4,7,0,E -> key_ready low 4 cycles; value_out=470 with value_valid one cycle.
//  keys 5,1,2,E -> range_err one cycle, value_out stays 470, entry cleared.
//  keys 1,2,3,9 -> digit_drop on 4th key; entry_bcd=12'h123; E -> value_out=123.
//  keys 9,8,B,7,E -> entry 12'h097 before E; value_out=97. Keys A,E -> value_out=0.
//  key_valid held high with E during CONVERT -> E accepted only after DONE, exactly once.
//  rst_n low mid-CONVERT after 4,7,E -> all outputs 0, no value_valid, key_ready=1.

Source files
------------

// File: rtl/balanca_price_entry.sv
// balanca_price_entry: keypad front end for the scale.
// Collects decimal key digits over a valid/ready handshake, echoes them as
// BCD, and on ENTER converts them to binary one digit per cycle, publishing
// the result as the centimos operand for the price datapath.
module balanca_price_entry #(
    parameter int unsigned OUT_W      = 9,
    parameter int unsigned MAX_VAL    = 511,
    parameter int unsigned MAX_DIGITS = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              key_valid,
    output logic                              key_ready,
    input  logic [3:0]                        key_code,
    output logic [4*MAX_DIGITS-1:0]           entry_bcd,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
    output logic [OUT_W-1:0]                  value_out,
    output logic                              value_valid,
    output logic                              range_err,
    output logic                              digit_drop
);

    localparam int unsigned ACC_W = 4 * MAX_DIGITS;
    localparam int unsigned CW    = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        S_ENTRY,
        S_CONVERT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_entry;
    logic [CW-1:0]      r_count;
    logic [ACC_W-1:0]   r_acc;
    logic [CW-1:0]      r_idx;
    logic [OUT_W-1:0]   r_value;
    logic               r_valid;
    logic               r_rerr;
    logic               r_drop;

    logic               w_ready;
    logic               w_accept;
    logic               w_is_digit;
    logic [CW-1:0]      w_last_idx;
    logic [CW-1:0]      w_pos;
    logic [3:0]         w_digit;
    logic [ACC_W-1:0]   w_acc_next;

    assign w_ready    = (r_state == S_ENTRY);
    assign w_accept   = key_valid && w_ready;
    assign w_is_digit = (key_code <= 4'd9);
    // An empty buffer still takes one conversion cycle (as the digit 0).
    assign w_last_idx = (r_count == '0) ? '0 : r_count - CW'(1);
    // Oldest digit sits in the highest occupied nibble, so walk downwards.
    assign w_pos      = w_last_idx - r_idx;
    assign w_acc_next = (r_acc << 3) + (r_acc << 1) + ACC_W'(w_digit);

    // Select the digit being folded into the accumulator this cycle.
    always_comb begin
        w_digit = '0;
        if (r_count != '0) begin
            for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
                if (CW'(i) == w_pos) begin
                    w_digit = r_entry[4*i +: 4];
                end
            end
        end
    end

    // Entry / conversion FSM with registered outputs and single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_ENTRY;
            r_entry <= '0;
            r_count <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_value <= '0;
            r_valid <= 1'b0;
            r_rerr  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_rerr  <= 1'b0;
            r_drop  <= 1'b0;
            case (r_state)
                S_ENTRY: begin
                    if (w_accept) begin
                        if (w_is_digit) begin
                            if (r_count < CW'(MAX_DIGITS)) begin
                                r_entry <= ACC_W'({r_entry, key_code});
                                r_count <= r_count + CW'(1);
                            end else begin
                                r_drop <= 1'b1;
                            end
                        end else begin
                            case (key_code)
                                4'hA: begin
                                    r_entry <= '0;
                                    r_count <= '0;
                                end
                                4'hB: begin
                                    if (r_count != '0) begin
                                        r_entry <= r_entry >> 4;
                                        r_count <= r_count - CW'(1);
                                    end
                                end
                                4'hE: begin
                                    r_acc   <= '0;
                                    r_idx   <= '0;
                                    r_state <= S_CONVERT;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_CONVERT: begin
                    r_acc <= w_acc_next;
                    if (r_idx == w_last_idx) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + CW'(1);
                    end
                end
                S_DONE: begin
                    if (32'(r_acc) <= MAX_VAL) begin
                        r_value <= OUT_W'(r_acc);
                        r_valid <= 1'b1;
                    end else begin
                        r_rerr  <= 1'b1;
                    end
                    r_entry <= '0;
                    r_count <= '0;
                    r_state <= S_ENTRY;
                end
                default: r_state <= S_ENTRY;
            endcase
        end
    end

    assign key_ready   = w_ready;
    assign entry_bcd   = r_entry;
    assign digit_count = r_count;
    assign value_out   = r_value;
    assign value_valid = r_valid;
    assign range_err   = r_rerr;
    assign digit_drop  = r_drop;

endmodule
